// File: rtl/ask_uart_pkg.sv
// Shared definitions for the ASK UART receive path: FSM encoding, frame shape
// and the moving-sum width helper.
package ask_uart_pkg;

  // Receiver FSM state encodings.
  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_START_ENC     = 3'd1;
  localparam logic [2:0] ST_DATA_ENC      = 3'd2;
  localparam logic [2:0] ST_STOP_ENC      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_START     = ST_START_ENC,
    ST_DATA      = ST_DATA_ENC,
    ST_STOP      = ST_STOP_ENC,
    ST_WAIT_IDLE = ST_WAIT_IDLE_ENC
  } rx_state_t;

  // 8N1 framing.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Width of the moving sum: magnitude width plus log2 of the window depth,
  // which is exactly enough to hold 2^log_win full-scale magnitudes.
  function automatic int sum_width(input int ask_width, input int log_win);
    return ask_width - 1 + log_win;
  endfunction

endpackage

// File: rtl/ask_envelope_detector.sv
// Envelope detector: rectifies signed ASK samples, keeps a moving sum over a
// 2^LOG_WIN window and turns it into a line level with hysteresis.
module ask_envelope_detector
  import ask_uart_pkg::*;
#(
  parameter int ASK_WIDTH = 8,
  parameter int LOG_WIN   = 5,
  parameter int THRESH_HI = 1024,
  parameter int THRESH_LO = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASK_WIDTH-1:0] i_sample,
  output logic                 o_line
);

  localparam int MW  = ASK_WIDTH - 1;
  localparam int WIN = 1 << LOG_WIN;
  localparam int SW  = sum_width(ASK_WIDTH, LOG_WIN);

  localparam logic [SW-1:0] c_hi = SW'(THRESH_HI);
  localparam logic [SW-1:0] c_lo = SW'(THRESH_LO);

  logic [MW-1:0]     w_mag;
  logic [MW-1:0]     w_oldest;
  logic [SW-1:0]     w_mag_ext;
  logic [SW-1:0]     w_old_ext;
  logic [WIN*MW-1:0] r_win;
  logic [SW-1:0]     r_sum;
  logic              r_line;

  // Negative samples carry no carrier energy and are clamped to zero.
  assign w_mag     = i_sample[ASK_WIDTH-1] ? '0 : i_sample[ASK_WIDTH-2:0];
  assign w_oldest  = r_win[WIN*MW-1 -: MW];
  assign w_mag_ext = {{LOG_WIN{1'b0}}, w_mag};
  assign w_old_ext = {{LOG_WIN{1'b0}}, w_oldest};
  assign o_line    = r_line;

  // Delay line and running sum: add the newest magnitude, drop the oldest.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win <= '0;
      r_sum <= '0;
    end else begin
      r_win <= {r_win[(WIN-1)*MW-1:0], w_mag};
      r_sum <= r_sum + w_mag_ext - w_old_ext;
    end
  end

  // Hysteresis comparator; idle line (carrier present) is mark.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line <= 1'b1;
    end else if (r_sum >= c_hi) begin
      r_line <= 1'b1;
    end else if (r_sum < c_lo) begin
      r_line <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_ask_uart_rx.sv
// ASK UART receiver: envelope detection, 8N1 deframing at CLKDIV clocks per
// bit, and a one-entry AXI-Stream output buffer.
//
// Output handshake: a byte transfers on every clock edge where o_tvalid and
// o_tready are both high. Once o_tvalid rises it stays high with o_tdata held
// stable until that transfer happens; o_tvalid never depends on o_tready.
module axis_ask_uart_rx
  import ask_uart_pkg::*;
#(
  parameter int ASK_WIDTH = 8,
  parameter int LOG_WIN   = 5,
  parameter int THRESH_HI = 1024,
  parameter int THRESH_LO = 512,
  parameter int CLKDIV    = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ASK_WIDTH-1:0] ask_rx,
  output logic [7:0]           o_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] c_bit_last  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKDIV / 2 - 1);
  localparam logic [BW-1:0] c_idx_last  = BW'(DATA_BITS - 1);

  logic                 w_line;
  logic                 r_line_q;
  rx_state_t            r_state;
  rx_state_t            w_state_nx;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nx;
  logic [BW-1:0]        r_bitidx;
  logic [BW-1:0]        w_bitidx_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;
  logic                 w_deliver;
  logic                 w_ferr;
  logic [7:0]           r_tdata;
  logic                 r_tvalid;
  logic                 r_frame_err;
  logic                 r_overrun;

  ask_envelope_detector #(
    .ASK_WIDTH (ASK_WIDTH),
    .LOG_WIN   (LOG_WIN),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_env (
    .clk      (clk),
    .rst      (rst),
    .i_sample (ask_rx),
    .o_line   (w_line)
  );

  // Previous line level, used to spot the mark-to-space start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line_q <= 1'b1;
    end else begin
      r_line_q <= w_line;
    end
  end

  // FSM and bit-timing registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_bitidx <= w_bitidx_nx;
      r_shift  <= w_shift_nx;
    end
  end

  // Next-state logic: mid-bit sampling of start, data and stop bits.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_bitidx_nx = r_bitidx;
    w_shift_nx  = r_shift;
    w_deliver   = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_line_q && !w_line) begin
          w_state_nx = ST_START;
          w_cnt_nx   = '0;
        end
      end
      ST_START: begin
        if (r_cnt == c_half_last) begin
          w_cnt_nx = '0;
          if (!w_line) begin
            w_state_nx  = ST_DATA;
            w_bitidx_nx = '0;
          end else begin
            // Line went back to mark before mid start bit: a glitch.
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_line, r_shift[DATA_BITS-1:1]};
          if (r_bitidx == c_idx_last) begin
            w_state_nx = ST_STOP;
          end else begin
            w_bitidx_nx = r_bitidx + BW'(1);
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nx = '0;
          if (w_line) begin
            w_deliver  = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_ferr     = 1'b1;
            w_state_nx = ST_WAIT_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        // Hold off re-arming until the line returns to mark so a long break
        // reports a single framing error.
        if (w_line) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // One-entry output buffer plus framing-error and overrun pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_tvalid || o_tready) begin
          r_tdata  <= r_shift;
          r_tvalid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_tvalid && o_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign o_tdata   = r_tdata;
  assign o_tvalid  = r_tvalid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axis_ask_uart_rx.sv
// Bench for axis_ask_uart_rx: a behavioural ASK transmitter drives noisy
// carrier samples; received bytes and pulses are scored against what each
// transmitted frame must produce under 8N1 rules.
`timescale 1ns/1ps
module tb_axis_ask_uart_rx;

  localparam int CLKDIV = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ask_rx = 8'h00;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       o_tready = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  logic [7:0] exp_q[$];

  // Transmitter line level and downstream ready behaviour (0 low, 1 high, 2 random).
  logic tx_line    = 1'b1;
  int   tready_mode = 1;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         gap;
  } vec_t;

  vec_t vecs[10];

  axis_ask_uart_rx #(
    .ASK_WIDTH (8),
    .LOG_WIN   (5),
    .THRESH_HI (1024),
    .THRESH_LO (512),
    .CLKDIV    (CLKDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ask_rx    (ask_rx),
    .o_tdata   (o_tdata),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Sample driver: mark = carrier of 90..110, space = noise of -128..10.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_line) ask_rx = 8'($urandom_range(110, 90));
      else         ask_rx = 8'(int'($urandom_range(138, 0)) - 128);
      case (tready_mode)
        0:       o_tready = 1'b0;
        1:       o_tready = 1'b1;
        default: o_tready = ($urandom_range(3, 0) != 0);
      endcase
    end
  end

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (rst && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte actual=0x%0h required=none", o_tdata);
      end else begin
        check("rx_byte", 32'(o_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    tx_line = 1'b0;
    wait_clks(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      tx_line = d[i];
      wait_clks(CLKDIV);
    end
    tx_line = stop_bit;
    wait_clks(CLKDIV);
    tx_line = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 32'(o_tvalid),  32'd0);
    check({tag, "_tdata"},  32'(o_tdata),   32'd0);
    check({tag, "_ferr"},   32'(frame_err), 32'd0);
    check({tag, "_ovr"},    32'(overrun),   32'd0);
    check({tag, "_busy"},   32'(rx_busy),   32'd0);
  endtask

  // Main sequence
  initial begin
    int exp_fe;
    int fe0;
    int ov0;
    int busy_seen;

    // Reset
    rst = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_clks(300);
    @(negedge clk);
    check("startup_idle", 32'(rx_busy), 32'd0);

    // Vector table: fixed idle/sequence cases, one bad stop, random tail.
    vecs[0] = '{8'h55, 1'b1, 300};
    vecs[1] = '{8'h00, 1'b1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0};
    vecs[3] = '{8'hA5, 1'b1, 0};
    vecs[4] = '{8'h18, 1'b1, 300};
    vecs[5] = '{8'h80, 1'b0, 300};
    for (int i = 6; i < 10; i++) begin
      vecs[i].data     = 8'($urandom_range(255, 0));
      vecs[i].stop_bit = ($urandom_range(3, 0) != 0);
      vecs[i].gap      = vecs[i].stop_bit ? int'($urandom_range(200, 0)) : 300;
    end

    exp_fe = fe_cnt;
    for (int i = 0; i < 10; i++) begin
      tready_mode = (i < 5) ? 1 : 2;
      if (vecs[i].stop_bit) exp_q.push_back(vecs[i].data);
      else                  exp_fe++;
      send_frame(vecs[i].data, vecs[i].stop_bit);
      check("vec_delivered", 32'(exp_q.size()), 32'd0);
      check("vec_frame_err", 32'(fe_cnt), 32'(exp_fe));
      wait_clks(vecs[i].gap);
    end
    wait_drain("table_drain", 200);
    check("table_overrun", 32'(ov_cnt), 32'd0);

    // Short carrier dropout must not start a frame.
    tready_mode = 1;
    wait_clks(50);
    fe0 = fe_cnt;
    tx_line = 1'b0;
    wait_clks(20);
    tx_line = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1;
    end
    check("glitch_busy", 32'(busy_seen), 32'd0);
    check("glitch_tvalid", 32'(o_tvalid), 32'd0);
    check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Break: long space yields one frame error and no byte.
    fe0 = fe_cnt;
    tx_line = 1'b0;
    wait_clks(1400);
    @(negedge clk);
    check("break_busy_mid", 32'(rx_busy), 32'd1);
    wait_clks(100);
    tx_line = 1'b1;
    wait_clks(200);
    @(negedge clk);
    check("break_ferr_count", 32'(fe_cnt - fe0), 32'd1);
    check("break_busy_end", 32'(rx_busy), 32'd0);
    check("break_tvalid", 32'(o_tvalid), 32'd0);

    // Backpressure: second byte overruns, first byte held.
    tready_mode = 0;
    wait_clks(2);
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(50);
    @(negedge clk);
    check("bp_tvalid", 32'(o_tvalid), 32'd1);
    check("bp_tdata", 32'(o_tdata), 32'h11);
    check("bp_overrun", 32'(ov_cnt - ov0), 32'd1);
    exp_q.push_back(8'h11);
    tready_mode = 1;
    wait_clks(10);
    @(negedge clk);
    check("bp_tvalid_fall", 32'(o_tvalid), 32'd0);
    check("bp_accepted", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame, held until that frame ends.
    wait_clks(100);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        wait_clks(400);
        @(negedge clk);
        check("pre_rst_busy", 32'(rx_busy), 32'd1);
        rst = 1'b0;
        wait_clks(2);
        @(negedge clk);
        check_reset_outputs("midrst");
      end
    join
    @(negedge clk);
    rst = 1'b1;
    wait_clks(300);
    @(negedge clk);
    check("post_rst_busy", 32'(rx_busy), 32'd0);
    check("post_rst_tvalid", 32'(o_tvalid), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    wait_drain("post_rst_byte", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
